mat_frame_ctrl: RTL and testbench

Parametrised serial framing controller for the matrix-multiply path. It parses framed operand packets from the UART receive byte stream into N×N byte matrices A and B. On a matched A/B job pair it starts the multiplier and streams the framed N×N result back through the UART transmit handshake. It sits between the `uart` instance and the matrix-multiply engine in `top`, and replaces the ad-hoc fixed 2×2 parser there.

---
 rtl/mat_frame_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_mat_frame_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mat_frame_ctrl.sv
// Serial framing controller: parses A/B operand frames from the UART byte stream,
// starts the multiplier on a matched job pair and streams the framed result back.
// Optional build macro: MAT_FRAME_CSUM_EN (trailing XOR checksum byte per input frame).
module mat_frame_ctrl #(
  parameter int N           = 2,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [N*N*8-1:0]  mat_a,
  output logic [N*N*8-1:0]  mat_b,
  input  logic [N*N*8-1:0]  mat_c,
  output logic              mul_start,
  input  logic              mul_done,
  output logic [7:0]        job_id,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam int NE = N * N;
  localparam int IW = $clog2(NE);
  localparam int TW = $clog2(TIMEOUT_CYC);

  localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] SOF_BYTE = 8'hFF;
  localparam logic [7:0] TX_SOF   = 8'hFE;
  localparam logic [7:0] TYPE_A   = 8'h00;
  localparam logic [7:0] TYPE_B   = 8'h01;

  typedef enum logic [3:0] {
    S_IDLE, S_TYPE, S_JOB, S_DATA,
`ifdef MAT_FRAME_CSUM_EN
    S_CSUM,
`endif
    S_RUN, S_TX_HDR, S_TX_JOB, S_TX_DATA
  } state_t;

  typedef enum logic [1:0] {
    ERR_TIMEOUT = 2'd0,
    ERR_TYPE    = 2'd1,
    ERR_JOB     = 2'd2,
    ERR_CSUM    = 2'd3
  } err_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [TW-1:0]     tmo_cnt;
  logic              a_loaded;
  logic              is_b;
  logic [7:0]        pending_job;
  logic [NE*8-1:0]   shadow;
  logic [NE*8-1:0]   shadow_wr;
  logic [NE*8-1:0]   commit_data;
  logic              in_frame;
  logic              commit;
`ifdef MAT_FRAME_CSUM_EN
  logic [7:0]        csum;
`endif

  // Shadow image with the current byte merged in, so a checksum-less frame can commit on its last byte.
  always_comb begin
    shadow_wr = shadow;
    shadow_wr[int'(idx) * 8 +: 8] = rx_byte;
  end

  always_comb begin
    in_frame = 1'b0;
    commit   = 1'b0;
`ifdef MAT_FRAME_CSUM_EN
    in_frame    = (state == S_TYPE) || (state == S_JOB) || (state == S_DATA) || (state == S_CSUM);
    commit      = rx_valid && (state == S_CSUM) && (rx_byte == csum);
    commit_data = shadow;
`else
    in_frame    = (state == S_TYPE) || (state == S_JOB) || (state == S_DATA);
    commit      = rx_valid && (state == S_DATA) && (idx == LAST_IDX);
    commit_data = shadow_wr;
`endif
  end

  // NOTE: frame staging registers carry no reset; each is written before any commit can read it,
  // and keeping them off the reset net lets them map to plain enabled flops.
  always_ff @(posedge clk) begin
    if (rx_valid) begin
      case (state)
        S_TYPE: begin
          is_b <= rx_byte[0];
`ifdef MAT_FRAME_CSUM_EN
          csum <= rx_byte;
`endif
        end
        S_JOB: begin
          pending_job <= rx_byte;
`ifdef MAT_FRAME_CSUM_EN
          csum <= csum ^ rx_byte;
`endif
        end
        S_DATA: begin
          shadow <= shadow_wr;
`ifdef MAT_FRAME_CSUM_EN
          csum <= csum ^ rx_byte;
`endif
        end
        default: ;
      endcase
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      tmo_cnt   <= '0;
      a_loaded  <= 1'b0;
      job_id    <= '0;
      mat_a     <= '0;
      mat_b     <= '0;
      mul_start <= 1'b0;
      busy      <= 1'b0;
      tx_byte   <= '0;
      tx_valid  <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
    end else begin
      err       <= 1'b0;
      mul_start <= 1'b0;

      // Inter-byte watchdog, only armed while a frame is being parsed.
      if (rx_valid) begin
        tmo_cnt <= '0;
      end else if (in_frame) begin
        if (tmo_cnt == TMO_LAST) begin
          err      <= 1'b1;
          err_code <= ERR_TIMEOUT;
          state    <= S_IDLE;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (rx_valid && rx_byte == SOF_BYTE) state <= S_TYPE;
        end
        S_TYPE: begin
          if (rx_valid) begin
            if (rx_byte == TYPE_A || rx_byte == TYPE_B) begin
              state <= S_JOB;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_TYPE;
              state    <= S_IDLE;
            end
          end
        end
        S_JOB: begin
          if (rx_valid) begin
            if (is_b && (!a_loaded || rx_byte != job_id)) begin
              err      <= 1'b1;
              err_code <= ERR_JOB;
              state    <= S_IDLE;
            end else begin
              idx   <= '0;
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            if (idx != LAST_IDX) idx <= idx + 1'b1;
`ifdef MAT_FRAME_CSUM_EN
            else state <= S_CSUM;
`endif
          end
        end
`ifdef MAT_FRAME_CSUM_EN
        S_CSUM: begin
          if (rx_valid && rx_byte != csum) begin
            err      <= 1'b1;
            err_code <= ERR_CSUM;
            state    <= S_IDLE;
          end
        end
`endif
        S_RUN: begin
          // A done coincident with our own start pulse belongs to an earlier job.
          if (mul_done && !mul_start) begin
            tx_byte  <= TX_SOF;
            tx_valid <= 1'b1;
            state    <= S_TX_HDR;
          end
        end
        S_TX_HDR: begin
          if (tx_ready) begin
            tx_byte <= job_id;
            state   <= S_TX_JOB;
          end
        end
        S_TX_JOB: begin
          if (tx_ready) begin
            tx_byte <= mat_c[7:0];
            idx     <= '0;
            state   <= S_TX_DATA;
          end
        end
        S_TX_DATA: begin
          if (tx_ready) begin
            if (idx == LAST_IDX) begin
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end else begin
              idx     <= idx + 1'b1;
              tx_byte <= mat_c[(int'(idx) + 1) * 8 +: 8];
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (commit) begin
        if (is_b) begin
          mat_b     <= commit_data;
          a_loaded  <= 1'b0;
          mul_start <= 1'b1;
          busy      <= 1'b1;
          state     <= S_RUN;
        end else begin
          mat_a    <= commit_data;
          job_id   <= pending_job;
          a_loaded <= 1'b1;
          state    <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mat_frame_ctrl.sv
// Directed self-checking bench for mat_frame_ctrl (N=2, short timeout); honours MAT_FRAME_CSUM_EN.
module tb_mat_frame_ctrl;

  localparam int N  = 2;
  localparam int NE = N * N;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic [7:0]        tx_byte;
  logic              tx_valid;
  logic              tx_ready;
  logic [NE*8-1:0]   mat_a;
  logic [NE*8-1:0]   mat_b;
  logic [NE*8-1:0]   mat_c;
  logic              mul_start;
  logic              mul_done;
  logic [7:0]        job_id;
  logic              err;
  logic [1:0]        err_code;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  logic [7:0] got [6];
  logic [7:0] exp_tx [6];

  always #5 clk = ~clk;

  mat_frame_ctrl #(.N(N), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mat_a(mat_a), .mat_b(mat_b), .mat_c(mat_c),
    .mul_start(mul_start), .mul_done(mul_done),
    .job_id(job_id), .err(err), .err_code(err_code), .busy(busy)
  );

  always @(posedge clk) if (mul_start) starts++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] typ, input logic [7:0] job,
                            input logic [31:0] data, input bit bad_csum);
    logic [7:0] cs;
    cs = typ ^ job;
    send(8'hFF);
    send(typ);
    send(job);
    for (int k = 0; k < NE; k++) begin
      send(data[k*8 +: 8]);
      cs = cs ^ data[k*8 +: 8];
    end
`ifdef MAT_FRAME_CSUM_EN
    send(cs ^ {7'd0, bad_csum});
`endif
  endtask

  task automatic recv(input int stall);
    int w;
    tx_ready = (stall == 0);
    for (int i = 0; i < 6; i++) begin
      w = 0;
      while (!tx_valid && w < 40) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("tx_present_%0d", i), tx_valid, 1);
      if (stall == 0 && i > 0) check($sformatf("tx_no_gap_%0d", i), w, 0);
      got[i] = tx_byte;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check($sformatf("tx_hold_%0d", i), {tx_valid, tx_byte}, {1'b1, got[i]});
      end
      tx_ready = 1'b1;
      @(negedge clk);
      if (stall != 0) tx_ready = 1'b0;
    end
    tx_ready = 1'b0;
  endtask

  task automatic check_tx();
    for (int i = 0; i < 6; i++) check($sformatf("tx_byte_%0d", i), got[i], exp_tx[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rx_byte  = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    mul_done = 1'b0;
    mat_c    = 32'h322B1613;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_tx", {tx_valid, tx_byte}, 9'd0);
    check("rst_mat_a", mat_a, 32'd0);
    check("rst_mat_b", mat_b, 32'd0);
    check("rst_ctrl", {mul_start, busy, err, err_code, job_id}, 13'd0);

    // B frame with no A loaded
    send(8'hFF); send(8'h01); send(8'h07);
    idle();
    check("b_no_a_err", {err, err_code}, {1'b1, 2'd2});
    idle();
    check("err_one_cycle", err, 0);

    // Happy path
    send_frame(8'h00, 8'h07, 32'h04030201, 1'b0);
    idle();
    check("a_commit", mat_a, 32'h04030201);
    check("a_job", job_id, 8'h07);
    send_frame(8'h01, 8'h07, 32'h08070605, 1'b0);
    idle();
    check("b_start", {mul_start, busy}, 2'b11);
    check("b_commit", mat_b, 32'h08070605);
    mul_done = 1'b1;
    idle();
    mul_done = 1'b0;
    check("start_pulse", {mul_start, starts}, {1'b0, 32'd1});
    idle(3);
    check("done_with_start_ignored", tx_valid, 0);
    mul_done = 1'b1;
    idle();
    mul_done = 1'b0;
    check("tx_hdr_latency", {tx_valid, tx_byte}, {1'b1, 8'hFE});
    recv(0);
    exp_tx = '{8'hFE, 8'h07, 8'h13, 8'h16, 8'h2B, 8'h32};
    check_tx();
    check("tx_done", {busy, tx_valid}, 2'b00);

    // Job mismatch
    send_frame(8'h00, 8'h07, 32'h44332211, 1'b0);
    idle();
    send(8'hFF); send(8'h01); send(8'h08);
    idle();
    check("mismatch_err", {err, err_code}, {1'b1, 2'd2});
    idle(2);
    check("mismatch_no_start", starts, 1);
    check("mismatch_mat_b", mat_b, 32'h08070605);
    check("mismatch_mat_a", mat_a, 32'h44332211);

    // Noise then bad type, then a valid A frame
    send(8'h55);
    idle();
    check("noise_ignored", err, 0);
    send(8'hFF); send(8'h03);
    idle();
    check("bad_type_err", {err, err_code}, {1'b1, 2'd1});
    send_frame(8'h00, 8'h09, 32'hA4A3A2A1, 1'b0);
    idle();
    check("after_bad_type_a", {job_id, mat_a}, {8'h09, 32'hA4A3A2A1});

    // Timeout after a partial frame
    send(8'hFF); send(8'h00); send(8'h0A); send(8'h01);
    idle();
    idle(15);
    check("timeout_not_early", err, 0);
    idle();
    check("timeout_err", {err, err_code}, {1'b1, 2'd0});
    check("timeout_no_commit", {job_id, mat_a}, {8'h09, 32'hA4A3A2A1});
    send_frame(8'h00, 8'h0B, 32'h04030201, 1'b0);
    idle();
    check("after_timeout_a", {job_id, mat_a}, {8'h0B, 32'h04030201});

`ifdef MAT_FRAME_CSUM_EN
    // Bad checksum is rejected without commit
    send_frame(8'h00, 8'h0C, 32'h0D0C0B0A, 1'b1);
    idle();
    check("csum_err", {err, err_code}, {1'b1, 2'd3});
    check("csum_no_commit", {job_id, mat_a}, {8'h0B, 32'h04030201});
`endif

    // Back-pressured result, with bytes arriving during RUN dropped
    send_frame(8'h00, 8'h0D, 32'h14131211, 1'b0);
    idle();
    check("bp_a_job", job_id, 8'h0D);
    mat_c = 32'hDDCCBBAA;
    send_frame(8'h01, 8'h0D, 32'h18171615, 1'b0);
    idle();
    check("bp_b_commit", {busy, mat_b}, {1'b1, 32'h18171615});
    send(8'hFF); send(8'h07);
    idle(2);
    check("run_rx_dropped", err, 0);
    mul_done = 1'b1;
    idle();
    mul_done = 1'b0;
    recv(10);
    exp_tx = '{8'hFE, 8'h0D, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    check_tx();
    check("bp_done", {busy, tx_valid, starts}, {2'b00, 32'd2});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
